// File: rtl/cache_controller.sv
// cache_controller: serializes CPU accesses across a 4-way cache and main memory, write-through with hit/miss statistics
module cache_controller #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_valid,
  output logic             cpu_ready,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_resp,
  output logic             cpu_err,
  output logic             cache_read,
  output logic             cache_write,
  output logic [31:0]      cache_addr,
  output logic [31:0]      cache_wdata,
  input  logic             cache_hit,
  input  logic [31:0]      cache_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, CACHE_WR, RESP} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, cwdata_q, cwdata_d, rdata_q, rdata_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] hit_q, hit_d, miss_q, miss_d;
  logic in_mem, tmo_last;
  assign in_mem = state_q == MEM_RD || state_q == MEM_WR;
  assign tmo_last = tmo_q == TW'(TIMEOUT - 1);
  assign cpu_ready = state_q == IDLE;
  assign cache_read = state_q == LOOKUP;
  assign cache_write = state_q == FILL || state_q == CACHE_WR;
  assign cpu_resp = state_q == RESP;
  assign mem_req = in_mem;
  assign mem_we = state_q == MEM_WR;
  assign cpu_rdata = rdata_q;
  assign cpu_err = err_q;
  assign cache_addr = addr_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign cache_wdata = cwdata_q;
  assign hit_count = hit_q;
  assign miss_count = miss_q;
  // Sequencing decisions; the wait counter restarts whenever a memory state is entered
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cwdata_d = cwdata_q;
    rdata_d = rdata_q;
    err_d = err_q;
    hit_d = hit_q;
    miss_d = miss_q;
    tmo_d = in_mem ? tmo_q + TW'(1) : '0;
    case (state_q)
      IDLE: if (cpu_valid) begin
        addr_d = cpu_addr;
        wdata_d = cpu_wdata;
        cwdata_d = cpu_we ? cpu_wdata : cwdata_q;
        err_d = 1'b0;
        state_d = cpu_we ? MEM_WR : LOOKUP;
      end
      LOOKUP: if (cache_hit) begin
        rdata_d = cache_rdata;
        hit_d = &hit_q ? hit_q : hit_q + CNT_W'(1);
        state_d = RESP;
      end else begin
        miss_d = &miss_q ? miss_q : miss_q + CNT_W'(1);
        state_d = MEM_RD;
      end
      MEM_RD: if (mem_ack) begin
        rdata_d = mem_rdata;
        cwdata_d = mem_rdata;
        state_d = FILL;
      end else if (tmo_last) begin
        rdata_d = '0;
        err_d = 1'b1;
        state_d = RESP;
      end
      MEM_WR: if (mem_ack) state_d = CACHE_WR;
      else if (tmo_last) begin
        rdata_d = '0;
        err_d = 1'b1;
        state_d = RESP;
      end
      FILL: state_d = RESP;
      CACHE_WR: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmo_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      cwdata_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cwdata_q <= cwdata_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: scoreboard bench for the cache sequencing controller
module tb_cache_controller;
  localparam int TIMEOUT = 4;
  localparam int CNT_W = 2;
  logic clk = 0, reset = 1;
  logic cpu_valid = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic cpu_ready, cpu_resp, cpu_err, cache_read, cache_write, mem_req, mem_we;
  logic [31:0] cpu_rdata, cache_addr, cache_wdata, mem_addr, mem_wdata;
  logic cache_hit;
  logic [31:0] cache_rdata;
  logic mem_ack = 0;
  logic [31:0] mem_rdata = 0;
  logic [CNT_W-1:0] hit_count, miss_count;

  typedef struct {logic [31:0] rdata; logic chk_rd; logic err; int cyc;} exp_t;
  exp_t sb[$];
  exp_t got;
  int pass_n = 0, total_n = 0, cyc = 0, resp_seen = 0;
  int wr_pulses = 0, req_cycles = 0, stable_bad = 0, waitc = 0, mem_wait = 0;
  int w0, r0;
  logic [31:0] last_cwdata = 0, last_addr = 0, mem_data = 0, hit_data = 0;
  logic last_we = 0, ack_en = 0, stray = 0, hit_en = 0, in_req = 0;
  logic [64:0] req_cap = 0;

  cache_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_resp(cpu_resp),
    .cpu_err(cpu_err), .cache_read(cache_read), .cache_write(cache_write), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_hit(cache_hit), .cache_rdata(cache_rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  assign cache_hit = hit_en;
  assign cache_rdata = hit_data;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Memory model: acks after mem_wait request cycles; stray forces an ack regardless
  initial forever begin
    @(negedge clk);
    mem_ack = stray;
    if (mem_req && ack_en) begin
      if (waitc == mem_wait) begin
        mem_ack = 1;
        mem_rdata = mem_data;
        waitc = 0;
      end else waitc++;
    end else if (!mem_req) waitc = 0;
  end

  // Monitor: counts strobes, checks request stability, pops the scoreboard on each response
  initial forever begin
    @(negedge clk);
    if (cache_write) begin
      wr_pulses++;
      last_cwdata = cache_wdata;
    end
    if (mem_req) begin
      req_cycles++;
      last_we = mem_we;
      last_addr = mem_addr;
      if (!in_req) begin
        in_req = 1;
        req_cap = {mem_we, mem_addr, mem_wdata};
      end else if (req_cap !== {mem_we, mem_addr, mem_wdata}) stable_bad++;
    end else in_req = 0;
    if (cpu_resp) begin
      resp_seen++;
      chk("resp_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        chk("resp_cycle", cyc, got.cyc);
        chk("resp_err", cpu_err, got.err);
        if (got.chk_rd) chk("resp_rdata", cpu_rdata, got.rdata);
      end
    end
  end

  task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] d, input int lat,
                        input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err, input bit push);
    exp_t e;
    int n;
    chk("ready_before", cpu_ready, 1);
    e.rdata = exp_rd;
    e.chk_rd = chk_rd;
    e.err = exp_err;
    e.cyc = cyc + lat;
    if (push) sb.push_back(e);
    n = resp_seen;
    cpu_valid = 1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    @(negedge clk);
    cpu_valid = 0;
    if (!push) return;
    for (int k = 0; k < 60 && resp_seen == n; k++) @(posedge clk);
    chk("resp_arrived", resp_seen - n, 1);
    @(negedge clk);
  endtask

  initial begin
    #2 reset = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ctrl", {cpu_ready, cpu_resp, cpu_err, cache_read, cache_write, mem_req, mem_we}, 7'b1000000);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_addrs", {cache_addr, mem_addr}, 0);
    chk("rst_wdata", {cache_wdata, mem_wdata}, 0);
    chk("rst_counts", {hit_count, miss_count}, 0);
    reset = 1;
    @(negedge clk);
    // read miss, ack after 2 wait cycles
    hit_en = 0; ack_en = 1; mem_wait = 2; mem_data = 32'hDEAD_BEEF;
    w0 = wr_pulses; r0 = req_cycles;
    cpu_op(0, 32'h40, 0, 6, 1, 32'hDEAD_BEEF, 0, 1);
    chk("miss_fill_pulses", wr_pulses - w0, 1);
    chk("miss_fill_data", last_cwdata, 32'hDEAD_BEEF);
    chk("miss_req_cycles", req_cycles - r0, 3);
    chk("miss_mem_we", last_we, 0);
    chk("miss_mem_addr", last_addr, 32'h40);
    chk("miss_counts", {hit_count, miss_count}, {2'd0, 2'd1});
    // read hit
    hit_en = 1; hit_data = 32'hDEAD_BEEF;
    w0 = wr_pulses; r0 = req_cycles;
    cpu_op(0, 32'h40, 0, 2, 1, 32'hDEAD_BEEF, 0, 1);
    chk("hit_no_req", req_cycles - r0, 0);
    chk("hit_no_write", wr_pulses - w0, 0);
    chk("hit_counts", {hit_count, miss_count}, {2'd1, 2'd1});
    // write-through, immediate ack
    hit_en = 0; mem_wait = 0;
    w0 = wr_pulses; r0 = req_cycles;
    cpu_op(1, 32'h80, 32'h1234_5678, 3, 0, 0, 0, 1);
    chk("wr_pulses", wr_pulses - w0, 1);
    chk("wr_cache_data", last_cwdata, 32'h1234_5678);
    chk("wr_mem_we", last_we, 1);
    chk("wr_req_cycles", req_cycles - r0, 1);
    chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("wr_cache_addr", cache_addr, 32'h80);
    chk("wr_counts", {hit_count, miss_count}, {2'd1, 2'd1});
    // read miss that never gets an ack
    ack_en = 0;
    w0 = wr_pulses; r0 = req_cycles;
    cpu_op(0, 32'h100, 0, 2 + TIMEOUT, 1, 0, 1, 1);
    chk("tmo_req_cycles", req_cycles - r0, TIMEOUT);
    chk("tmo_no_write", wr_pulses - w0, 0);
    chk("tmo_ready_after", cpu_ready, 1);
    chk("tmo_counts", {hit_count, miss_count}, {2'd1, 2'd2});
    // reset while waiting in MEM_RD, stray ack afterwards
    w0 = wr_pulses;
    cpu_op(0, 32'h140, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10 && !mem_req; k++) @(negedge clk);
    chk("abort_in_mem_rd", mem_req, 1);
    reset = 0;
    #1;
    chk("abort_ctrl", {cpu_ready, cpu_resp, cpu_err, cache_read, cache_write, mem_req, mem_we}, 7'b1000000);
    chk("abort_data", {cpu_rdata, cache_addr, mem_addr}, 0);
    chk("abort_counts", {hit_count, miss_count}, 0);
    @(posedge clk);
    stray = 1;
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    stray = 0;
    @(negedge clk);
    chk("stray_ignored", {cpu_ready, mem_req, cache_read}, 3'b100);
    chk("abort_no_write", wr_pulses - w0, 0);
    // next request served normally
    ack_en = 1; mem_wait = 0; mem_data = 32'hCAFE_F00D;
    cpu_op(0, 32'h40, 0, 4, 1, 32'hCAFE_F00D, 0, 1);
    chk("post_abort_counts", {hit_count, miss_count}, {2'd0, 2'd1});
    // saturating hit counter
    hit_en = 1; hit_data = 32'h0BAD_C0DE;
    for (int i = 0; i < 5; i++) begin
      cpu_op(0, 32'h40, 0, 2, 1, 32'h0BAD_C0DE, 0, 1);
      chk("hit_sat", hit_count, (i < 3) ? i + 1 : 3);
    end
    chk("sb_drained", sb.size(), 0);
    chk("mem_stable", stable_bad, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
